// File: rtl/ysyx_23060136_wr_arbiter.sv
// ysyx_23060136_wr_arbiter
//    Two-requester arbiter for the single SoC AXI4 write path (AW/W/B).
//    M0 = D-cache writeback (bursts), M1 = LSU uncached store (single beat).
//    A grant covers one whole transaction (AW, every W beat, B), and ties are
//    broken round-robin.
// Ports:
//    clk, rst             clock, asynchronous active-high reset
//    mN_aw*/mN_awready    AW request / accept for requester N
//    mN_w*/mN_wready      W beats / accept for requester N
//    mN_b*/mN_bready      B response / accept for requester N
//    io_master_*          SoC-side AW/W/B channels
//    err_wlast            sticky: a wlast disagreed with the latched awlen
//    busy                 a transaction is in progress (state != IDLE)
module ysyx_23060136_wr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   // requester 0
   input  logic                m0_awvalid,
   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic [ID_W-1:0]     m0_awid,
   input  logic [7:0]          m0_awlen,
   input  logic [2:0]          m0_awsize,
   input  logic [1:0]          m0_awburst,
   output logic                m0_awready,
   input  logic                m0_wvalid,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wlast,
   output logic                m0_wready,
   output logic                m0_bvalid,
   output logic [1:0]          m0_bresp,
   output logic [ID_W-1:0]     m0_bid,
   input  logic                m0_bready,
   // requester 1
   input  logic                m1_awvalid,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [ID_W-1:0]     m1_awid,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   output logic                m1_awready,
   input  logic                m1_wvalid,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   output logic                m1_wready,
   output logic                m1_bvalid,
   output logic [1:0]          m1_bresp,
   output logic [ID_W-1:0]     m1_bid,
   input  logic                m1_bready,
   // SoC side
   output logic                io_master_awvalid,
   output logic [ADDR_W-1:0]   io_master_awaddr,
   output logic [ID_W-1:0]     io_master_awid,
   output logic [7:0]          io_master_awlen,
   output logic [2:0]          io_master_awsize,
   output logic [1:0]          io_master_awburst,
   input  logic                io_master_awready,
   output logic                io_master_wvalid,
   output logic [DATA_W-1:0]   io_master_wdata,
   output logic [DATA_W/8-1:0] io_master_wstrb,
   output logic                io_master_wlast,
   input  logic                io_master_wready,
   input  logic                io_master_bvalid,
   input  logic [1:0]          io_master_bresp,
   input  logic [ID_W-1:0]     io_master_bid,
   output logic                io_master_bready,
   output logic                err_wlast,
   output logic                busy
);

   typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

   state_t     state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic [7:0] len_q, len_d;
   logic       err_wlast_q, err_wlast_d;
   logic       winner;

   // granted requester's view of its own channels
   logic                sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
   logic [7:0]          sel_awlen;
   assign sel_awvalid = grant_q ? m1_awvalid : m0_awvalid;
   assign sel_awlen   = grant_q ? m1_awlen   : m0_awlen;
   assign sel_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
   assign sel_wlast   = grant_q ? m1_wlast   : m0_wlast;
   assign sel_bready  = grant_q ? m1_bready  : m0_bready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;   // M0 wins the first tie
         beat_cnt_q   <= 8'd0;
         len_q        <= 8'd0;
         err_wlast_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         len_q        <= len_d;
         err_wlast_q  <= err_wlast_d;
      end
   end

   // next state
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      len_d        = len_q;
      err_wlast_d  = err_wlast_q;
      // on a tie the requester that did not win last time goes next
      winner       = (m0_awvalid && m1_awvalid) ? ~last_grant_q : m1_awvalid;
      case (state_q)
         S_IDLE: begin
            if (m0_awvalid || m1_awvalid) begin
               grant_d      = winner;
               last_grant_d = winner;
               state_d      = S_AW;
            end
         end
         S_AW: begin
            if (sel_awvalid && io_master_awready) begin
               len_d      = sel_awlen;
               beat_cnt_d = 8'd0;
               state_d    = S_W;
            end
         end
         S_W: begin
            if (sel_wvalid && io_master_wready) begin
               // beat_cnt holds the index of the beat being transferred
               if ((beat_cnt_q == len_q) != sel_wlast) err_wlast_d = 1'b1;
               if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
               if (sel_wlast) state_d = S_B;   // wlast decides, even on error
            end
         end
         S_B: begin
            if (io_master_bvalid && sel_bready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // channel routing: everything outside its phase or off-grant is zero
   always_comb begin
      io_master_awvalid = 1'b0;
      io_master_awaddr  = '0;
      io_master_awid    = '0;
      io_master_awlen   = '0;
      io_master_awsize  = '0;
      io_master_awburst = '0;
      io_master_wvalid  = 1'b0;
      io_master_wdata   = '0;
      io_master_wstrb   = '0;
      io_master_wlast   = 1'b0;
      io_master_bready  = 1'b0;
      m0_awready = 1'b0;  m1_awready = 1'b0;
      m0_wready  = 1'b0;  m1_wready  = 1'b0;
      m0_bvalid  = 1'b0;  m1_bvalid  = 1'b0;
      m0_bresp   = '0;    m1_bresp   = '0;
      m0_bid     = '0;    m1_bid     = '0;
      case (state_q)
         S_AW: begin
            io_master_awvalid = sel_awvalid;
            io_master_awaddr  = grant_q ? m1_awaddr  : m0_awaddr;
            io_master_awid    = grant_q ? m1_awid    : m0_awid;
            io_master_awlen   = sel_awlen;
            io_master_awsize  = grant_q ? m1_awsize  : m0_awsize;
            io_master_awburst = grant_q ? m1_awburst : m0_awburst;
            if (grant_q) m1_awready = io_master_awready;
            else         m0_awready = io_master_awready;
         end
         S_W: begin
            io_master_wvalid = sel_wvalid;
            io_master_wdata  = grant_q ? m1_wdata : m0_wdata;
            io_master_wstrb  = grant_q ? m1_wstrb : m0_wstrb;
            io_master_wlast  = sel_wlast;
            if (grant_q) m1_wready = io_master_wready;
            else         m0_wready = io_master_wready;
         end
         S_B: begin
            io_master_bready = sel_bready;
            if (grant_q) begin
               m1_bvalid = io_master_bvalid;
               m1_bresp  = io_master_bresp;
               m1_bid    = io_master_bid;
            end else begin
               m0_bvalid = io_master_bvalid;
               m0_bresp  = io_master_bresp;
               m0_bid    = io_master_bid;
            end
         end
         default: ;
      endcase
   end

   assign err_wlast = err_wlast_q;
   assign busy      = (state_q != S_IDLE);

endmodule
